// File: rtl/ss_axi_isolate_seq.sv
// ss_axi_isolate_seq
// Isolation sequencer for the secure subsystem's outbound AXI masters.
// Tracks outstanding AW/AR transactions per port from handshake pulses,
// throttles each port at its outstanding limit, and on an isolate request
// gates all ports, waits for them to drain (or for a drain timeout) and
// then reports isolation.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   isolate_i         asynchronous isolate request (synchronised here)
//   aw_hs_i, ar_hs_i  per-port request handshake pulses (increment)
//   b_hs_i            per-port write response handshake pulses (decrement)
//   rlast_hs_i        per-port last read beat handshake pulses (decrement)
//   gate_o            per-port: 1 = do not accept new AW/AR
//   busy_o            per-port: 1 = outstanding counter non-zero
//   isolated_o        all ports gated and drained (or timed out)
//   timeout_o         sticky: last isolation was forced by the drain timeout
//   underflow_o       sticky: a completion arrived with the counter at 0
//   drain_cycles_o    length of the last completed drain, in cycles
//
// Optional feature macro: SS_AXI_ISOLATE_PERF_EN
//   defined   -> drain_cycles_o reports the saturating DRAIN-cycle count
//   undefined -> drain_cycles_o is tied to 0
module ss_axi_isolate_seq #(
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned MaxPending    = 8,
    parameter int unsigned SyncStages    = 3,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                isolate_i,
    input  logic [NumPorts-1:0] aw_hs_i,
    input  logic [NumPorts-1:0] ar_hs_i,
    input  logic [NumPorts-1:0] b_hs_i,
    input  logic [NumPorts-1:0] rlast_hs_i,
    output logic [NumPorts-1:0] gate_o,
    output logic [NumPorts-1:0] busy_o,
    output logic                isolated_o,
    output logic                timeout_o,
    output logic                underflow_o,
    output logic [31:0]         drain_cycles_o
);

    localparam int unsigned CntW  = $clog2(MaxPending + 1);
    localparam int unsigned CntW1 = CntW + 1;
    localparam int unsigned TmrW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ISOLATED
    } state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] sync_q;
    logic                  iso_s;
    logic [CntW-1:0]       cnt_q [NumPorts];
    logic [CntW-1:0]       cnt_d [NumPorts];
    logic [NumPorts-1:0]   uf_hit;
    logic [TmrW-1:0]       timer_q, timer_d;
    logic                  timeout_q, timeout_d;
    logic                  underflow_q;
    logic                  all_idle;
    logic                  drain_done;

    // Synchroniser resets to 1 so the block comes up isolated.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[SyncStages-2:0], isolate_i};
    end
    assign iso_s = sync_q[SyncStages-1];

    // Returns {underflow, next count}. Completions are taken off first and
    // clamp at zero; new issues are then added and saturate at MaxPending.
    function automatic logic [CntW:0] cnt_step(
        input logic [CntW-1:0] cnt,
        input logic            inc_a,
        input logic            inc_b,
        input logic            dec_a,
        input logic            dec_b
    );
        logic [CntW1-1:0] inc, dec, cur, nxt;
        logic             uf;
        inc = CntW1'(inc_a) + CntW1'(inc_b);
        dec = CntW1'(dec_a) + CntW1'(dec_b);
        cur = CntW1'(cnt);
        uf  = (dec > cur);
        nxt = uf ? inc : (cur - dec + inc);
        if (nxt > CntW1'(MaxPending)) nxt = CntW1'(MaxPending);
        return {uf, nxt[CntW-1:0]};
    endfunction

    always_comb begin
        uf_hit = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            cnt_d[p] = '0;
            {uf_hit[p], cnt_d[p]} = cnt_step(cnt_q[p], aw_hs_i[p], ar_hs_i[p],
                                             b_hs_i[p], rlast_hs_i[p]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NumPorts; p++) cnt_q[p] <= cnt_d[p];
            underflow_q <= underflow_q | (|uf_hit);
        end
    end

    // Gating at MaxPending-1 keeps the limit even with AW and AR together.
    always_comb begin
        busy_o = '0;
        gate_o = '1;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            busy_o[p] = (cnt_q[p] != '0);
            gate_o[p] = (state_q != ST_RUN) || (cnt_q[p] >= CntW'(MaxPending - 1));
        end
    end
    assign all_idle = ~|busy_o;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        drain_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (iso_s) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end
            end
            ST_DRAIN: begin
                timer_d = timer_q + TmrW'(1);
                // Abort has priority over a drain completing in the same cycle.
                if (!iso_s) begin
                    state_d = ST_RUN;
                end else if (all_idle) begin
                    state_d    = ST_ISOLATED;
                    timeout_d  = 1'b0;
                    drain_done = 1'b1;
                end else if ((TimeoutCycles != 0) &&
                             (timer_q == TmrW'(TimeoutCycles - 1))) begin
                    state_d    = ST_ISOLATED;
                    timeout_d  = 1'b1;
                    drain_done = 1'b1;
                end
            end
            ST_ISOLATED: begin
                if (!iso_s) state_d = ST_RUN;
            end
            default: state_d = ST_ISOLATED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ISOLATED;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign isolated_o  = (state_q == ST_ISOLATED);
    assign timeout_o   = timeout_q;
    assign underflow_o = underflow_q;

`ifdef SS_AXI_ISOLATE_PERF_EN
    logic [31:0] perf_q, perf_d, drain_cycles_q;

    assign perf_d = (perf_q == '1) ? perf_q : perf_q + 32'd1;

    // perf_d at the exit edge already includes the final DRAIN cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q         <= '0;
            drain_cycles_q <= '0;
        end else begin
            if (state_q == ST_RUN && state_d == ST_DRAIN) perf_q <= '0;
            else if (state_q == ST_DRAIN)                 perf_q <= perf_d;
            if (drain_done) drain_cycles_q <= perf_d;
        end
    end
    assign drain_cycles_o = drain_cycles_q;
`else
    assign drain_cycles_o = '0;
`endif

endmodule

// File: tb/tb_ss_axi_isolate_seq.sv
// Testbench for ss_axi_isolate_seq: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_ss_axi_isolate_seq;

    localparam int unsigned NP = 2;
    localparam int unsigned MP = 4;
    localparam int unsigned SS = 3;
    localparam int unsigned TO = 16;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_ISO   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        isolate = 1'b1;
    logic [1:0]  aw = '0, ar = '0, b = '0, rl = '0;
    logic [1:0]  gate, busy;
    logic        isolated, timeout, underflow;
    logic [31:0] drain_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: isolate history, pending counts, mode and flags.
    bit     m_sync [3];
    int     m_cnt  [2];
    int     m_mode;
    int     m_timer;
    bit     m_to, m_uf;
    longint m_dcnt, m_dcyc;

    always #5 clk = ~clk;

    ss_axi_isolate_seq #(
        .NumPorts      (NP),
        .MaxPending    (MP),
        .SyncStages    (SS),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .isolate_i      (isolate),
        .aw_hs_i        (aw),
        .ar_hs_i        (ar),
        .b_hs_i         (b),
        .rlast_hs_i     (rl),
        .gate_o         (gate),
        .busy_o         (busy),
        .isolated_o     (isolated),
        .timeout_o      (timeout),
        .underflow_o    (underflow),
        .drain_cycles_o (drain_cycles)
    );

    function automatic logic [1:0] exp_gate();
        logic [1:0] g;
        for (int p = 0; p < 2; p++) g[p] = (m_mode != M_RUN) || (m_cnt[p] >= int'(MP) - 1);
        return g;
    endfunction

    function automatic logic [1:0] exp_busy();
        logic [1:0] v;
        for (int p = 0; p < 2; p++) v[p] = (m_cnt[p] != 0);
        return v;
    endfunction

    function automatic logic [31:0] exp_dc();
`ifdef SS_AXI_ISOLATE_PERF_EN
        return 32'(m_dcyc);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_update();
        bit iso_s, idle;
        if (rst) begin
            m_sync = '{1, 1, 1};
            m_cnt  = '{0, 0};
            m_mode = M_ISO; m_timer = 0; m_to = 0; m_uf = 0; m_dcnt = 0; m_dcyc = 0;
            return;
        end
        iso_s = m_sync[2];
        idle  = (m_cnt[0] == 0) && (m_cnt[1] == 0);
        case (m_mode)
            M_RUN: if (iso_s) begin m_mode = M_DRAIN; m_timer = 0; m_dcnt = 0; end
            M_DRAIN: begin
                if (m_dcnt < 64'hFFFF_FFFF) m_dcnt++;
                if (!iso_s) m_mode = M_RUN;
                else if (idle) begin m_mode = M_ISO; m_to = 0; m_dcyc = m_dcnt; end
                else if (m_timer == int'(TO) - 1) begin m_mode = M_ISO; m_to = 1; m_dcyc = m_dcnt; end
                else m_timer++;
            end
            default: if (!iso_s) m_mode = M_RUN;
        endcase
        for (int p = 0; p < 2; p++) begin
            int inc = int'(aw[p]) + int'(ar[p]);
            int dec = int'(b[p]) + int'(rl[p]);
            if (dec > m_cnt[p]) begin m_uf = 1; m_cnt[p] = 0; end
            else m_cnt[p] -= dec;
            m_cnt[p] += inc;
            if (m_cnt[p] > int'(MP)) m_cnt[p] = int'(MP);
        end
        m_sync[2] = m_sync[1];
        m_sync[1] = m_sync[0];
        m_sync[0] = isolate;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic step(input bit r, input bit iso, input logic [1:0] a_w,
                        input logic [1:0] a_r, input logic [1:0] b_v, input logic [1:0] r_l);
        rst = r; isolate = iso; aw = a_w; ar = a_r; b = b_v; rl = r_l;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        n_cmp++; if (gate !== 2'b11) begin n_bad++; $display("FAIL rst_gate: got %b expected 11", gate); end
        n_cmp++; if (isolated !== 1'b1) begin n_bad++; $display("FAIL rst_isolated: got %b expected 1", isolated); end
        n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL rst_busy: got %b expected 00", busy); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b expected 0", timeout); end
        n_cmp++; if (underflow !== 1'b0) begin n_bad++; $display("FAIL rst_underflow: got %b expected 0", underflow); end
        n_cmp++; if (drain_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_drain_cycles: got %0d expected 0", drain_cycles); end
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            n_cmp++;
            if (isolated !== (i < 4)) begin
                n_bad++; $display("FAIL release_isolated c%0d: got %b expected %b", i, isolated, (i < 4));
            end
        end
        n_cmp++; if (gate !== 2'b00) begin n_bad++; $display("FAIL release_gate: got %b expected 00", gate); end
    endtask

    task automatic test_limit();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'b01, 0, 0, 0);
            n_cmp++;
            if (gate !== {1'b0, i == 2}) begin
                n_bad++; $display("FAIL limit_gate n%0d: got %b expected %b", i + 1, gate, {1'b0, i == 2});
            end
        end
        step(0, 0, 0, 0, 2'b01, 0);
        n_cmp++; if (gate !== 2'b00) begin n_bad++; $display("FAIL limit_release_gate: got %b expected 00", gate); end
        n_cmp++; if (busy !== 2'b01) begin n_bad++; $display("FAIL limit_busy: got %b expected 01", busy); end
    endtask

    task automatic test_same_cycle();
        step(0, 0, 2'b01, 0, 2'b01, 0);  // cnt0 2 -> 2
        n_cmp++; if (gate !== 2'b00) begin n_bad++; $display("FAIL same_cycle_gate: got %b expected 00", gate); end
        step(0, 0, 0, 0, 2'b10, 0);      // completion on idle port 1
        n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_flag: got %b expected 1", underflow); end
        n_cmp++; if (busy !== 2'b01) begin n_bad++; $display("FAIL underflow_busy: got %b expected 01", busy); end
        step(0, 0, 2'b01, 0, 0, 0);      // cnt0 2 -> 3 proves it held at 2
        n_cmp++; if (gate !== 2'b01) begin n_bad++; $display("FAIL same_cycle_hold: got %b expected 01", gate); end
        step(0, 0, 0, 0, 2'b01, 0);      // back to cnt0 = 2
        n_cmp++; if (gate !== 2'b00) begin n_bad++; $display("FAIL same_cycle_restore: got %b expected 00", gate); end
    endtask

    task automatic test_drain_clean();
        for (int i = 1; i <= 13; i++) begin
            step(0, 1, 0, 0, (i == 10 || i == 11) ? 2'b01 : 2'b00, 0);
            n_cmp++;
            if (gate !== ((i >= 4) ? 2'b11 : 2'b00)) begin
                n_bad++; $display("FAIL drain_gate c%0d: got %b expected %b", i, gate, (i >= 4) ? 2'b11 : 2'b00);
            end
            n_cmp++;
            if (isolated !== (i >= 12)) begin
                n_bad++; $display("FAIL drain_isolated c%0d: got %b expected %b", i, isolated, (i >= 12));
            end
        end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL drain_timeout: got %b expected 0", timeout); end
        n_cmp++; if (drain_cycles !== exp_dc()) begin n_bad++; $display("FAIL drain_cycles_clean: got %0d expected %0d", drain_cycles, exp_dc()); end
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 0, 0);
        n_cmp++; if (isolated !== 1'b0) begin n_bad++; $display("FAIL drain_exit_isolated: got %b expected 0", isolated); end
    endtask

    task automatic test_timeout();
        step(0, 0, 2'b10, 0, 0, 0);      // cnt1 = 1
        for (int i = 1; i <= 21; i++) begin
            step(0, 1, 0, 0, 0, 0);
            n_cmp++;
            if (isolated !== (i >= 20)) begin
                n_bad++; $display("FAIL timeout_isolated c%0d: got %b expected %b", i, isolated, (i >= 20));
            end
        end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b expected 1", timeout); end
        n_cmp++; if (busy !== 2'b10) begin n_bad++; $display("FAIL timeout_busy: got %b expected 10", busy); end
        n_cmp++; if (drain_cycles !== exp_dc()) begin n_bad++; $display("FAIL drain_cycles_timeout: got %0d expected %0d", drain_cycles, exp_dc()); end
        step(0, 1, 0, 0, 0, 2'b10);      // late completion
        n_cmp++; if (busy !== 2'b00) begin n_bad++; $display("FAIL late_completion_busy: got %b expected 00", busy); end
        n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL late_underflow: got %b expected 1", underflow); end
        for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 0, 0);
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b expected 1", timeout); end
    endtask

    task automatic test_abort();
        step(0, 0, 2'b01, 0, 0, 0);      // cnt0 = 1
        for (int i = 1; i <= 14; i++) begin
            step(0, (i <= 6), 0, 0, 0, 0);
            n_cmp++;
            if (isolated !== 1'b0) begin n_bad++; $display("FAIL abort_isolated c%0d: got %b expected 0", i, isolated); end
            n_cmp++;
            if (gate !== ((i >= 4 && i <= 9) ? 2'b11 : 2'b00)) begin
                n_bad++; $display("FAIL abort_gate c%0d: got %b expected %b", i, gate, (i >= 4 && i <= 9) ? 2'b11 : 2'b00);
            end
        end
        n_cmp++; if (drain_cycles !== exp_dc()) begin n_bad++; $display("FAIL abort_drain_cycles: got %0d expected %0d", drain_cycles, exp_dc()); end
        step(0, 0, 0, 0, 2'b01, 0);      // cnt0 back to 0
    endtask

    task automatic test_random();
        bit iso = 0;
        bit slow = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] a_w = '0, a_r = '0, b_v = '0, r_l = '0;
            logic [1:0] g;
            bit r;
            int pct;
            if (cyc % 200 == 0) slow = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 39) == 0) iso = ~iso;
            r   = ($urandom_range(0, 499) == 0);
            g   = exp_gate();
            pct = slow ? 3 : 30;
            for (int p = 0; p < 2; p++) begin
                int avail = m_cnt[p];
                bit issue_ok = !g[p] || (m_cnt[p] <= 2 && $urandom_range(0, 49) == 0);
                if (issue_ok) begin
                    a_w[p] = ($urandom_range(0, 9) < 3);
                    a_r[p] = ($urandom_range(0, 9) < 3);
                end
                if (avail > 0 && $urandom_range(0, 99) < pct) begin b_v[p] = 1'b1; avail--; end
                if (avail > 0 && $urandom_range(0, 99) < pct) r_l[p] = 1'b1;
                if ($urandom_range(0, 299) == 0) b_v[p] = 1'b1;
            end
            step(r, iso, a_w, a_r, b_v, r_l);
            n_cmp++; if (gate !== exp_gate()) begin n_bad++; $display("FAIL rnd_gate cyc%0d: got %b expected %b", cyc, gate, exp_gate()); end
            n_cmp++; if (busy !== exp_busy()) begin n_bad++; $display("FAIL rnd_busy cyc%0d: got %b expected %b", cyc, busy, exp_busy()); end
            n_cmp++; if (isolated !== (m_mode == M_ISO)) begin n_bad++; $display("FAIL rnd_isolated cyc%0d: got %b expected %b", cyc, isolated, (m_mode == M_ISO)); end
            n_cmp++; if (timeout !== m_to) begin n_bad++; $display("FAIL rnd_timeout cyc%0d: got %b expected %b", cyc, timeout, m_to); end
            n_cmp++; if (underflow !== m_uf) begin n_bad++; $display("FAIL rnd_underflow cyc%0d: got %b expected %b", cyc, underflow, m_uf); end
            n_cmp++; if (drain_cycles !== exp_dc()) begin n_bad++; $display("FAIL rnd_drain_cycles cyc%0d: got %0d expected %0d", cyc, drain_cycles, exp_dc()); end
        end
    endtask

    initial begin
        test_reset();
        test_limit();
        test_same_cycle();
        test_drain_clean();
        test_timeout();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
